// File: rtl/axil_reg_if_wr_pkg.sv
// axil_reg_if_wr_pkg
// Shared constants and helpers for the AXI-lite register write bridge.
//   RESP_OKAY  : AXI response code returned on every write
//   cnt_width  : width of the ack-timeout down-counter for a given TIMEOUT
package axil_reg_if_wr_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // The counter only has to hold TIMEOUT-1, but never shrink below one bit.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout);
    if (w < 1) begin
      cnt_width = 1;
    end else begin
      cnt_width = w;
    end
  endfunction

endpackage

// File: rtl/axil_reg_if_wr.sv
// axil_reg_if_wr
// AXI-lite write slave that turns each AW/W pair into one held write request
// on a simple register interface, with a bounded ack timeout.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   s_axil_aw*                  write address channel (awprot ignored)
//   s_axil_w*                   write data channel
//   s_axil_b*                   write response channel (always OKAY)
//   reg_wr_addr/data/strb       held address, data and byte strobes
//   reg_wr_en                   write request, held until ack or timeout
//   reg_wr_wait                 stall from register logic, freezes timeout
//   reg_wr_ack                  completion from register logic
module axil_reg_if_wr
  import axil_reg_if_wr_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic [STRB_WIDTH-1:0] reg_wr_strb,
  output logic                  reg_wr_en,
  input  logic                  reg_wr_wait,
  input  logic                  reg_wr_ack
);

  localparam int                CNT_W    = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);

  logic                  aw_held_r, aw_held_s;
  logic [ADDR_WIDTH-1:0] addr_r,    addr_s;
  logic                  w_held_r,  w_held_s;
  logic [DATA_WIDTH-1:0] data_r,    data_s;
  logic [STRB_WIDTH-1:0] strb_r,    strb_s;
  logic                  bvalid_r,  bvalid_s;
  logic                  en_r,      en_s;
  logic [CNT_W-1:0]      cnt_r,     cnt_s;
  logic                  complete_s;

  // Protection bits carry no meaning for the register space.
  logic unused_awprot;
  assign unused_awprot = ^s_axil_awprot;

  // Next-state logic for holding registers, response, request and timeout.
  always_comb begin
    complete_s = en_r && (reg_wr_ack || (cnt_r == CNT_ZERO));
    aw_held_s  = aw_held_r;
    addr_s     = addr_r;
    w_held_s   = w_held_r;
    data_s     = data_r;
    strb_s     = strb_r;
    bvalid_s   = bvalid_r;
    cnt_s      = cnt_r;

    if (complete_s) begin
      aw_held_s = 1'b0;
    end else if (s_axil_awvalid && !aw_held_r) begin
      aw_held_s = 1'b1;
      addr_s    = s_axil_awaddr;
    end else begin
      aw_held_s = aw_held_r;
    end

    if (complete_s) begin
      w_held_s = 1'b0;
    end else if (s_axil_wvalid && !w_held_r) begin
      w_held_s = 1'b1;
      data_s   = s_axil_wdata;
      strb_s   = s_axil_wstrb;
    end else begin
      w_held_s = w_held_r;
    end

    // Completion wins over a same-cycle bready so a fresh B is never lost.
    if (complete_s) begin
      bvalid_s = 1'b1;
    end else if (s_axil_bready) begin
      bvalid_s = 1'b0;
    end else begin
      bvalid_s = bvalid_r;
    end

    // A buffered pair waits until the previous B has been taken.
    en_s = aw_held_s && w_held_s && !bvalid_s;

    if (!en_r) begin
      cnt_s = CNT_LOAD;
    end else if (!reg_wr_wait && (cnt_r != CNT_ZERO)) begin
      cnt_s = cnt_r - CNT_ONE;
    end else begin
      cnt_s = cnt_r;
    end
  end

  // State register with asynchronous reset on every flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held_r <= 1'b0;
      addr_r    <= {ADDR_WIDTH{1'b0}};
      w_held_r  <= 1'b0;
      data_r    <= {DATA_WIDTH{1'b0}};
      strb_r    <= {STRB_WIDTH{1'b0}};
      bvalid_r  <= 1'b0;
      en_r      <= 1'b0;
      cnt_r     <= CNT_LOAD;
    end else begin
      aw_held_r <= aw_held_s;
      addr_r    <= addr_s;
      w_held_r  <= w_held_s;
      data_r    <= data_s;
      strb_r    <= strb_s;
      bvalid_r  <= bvalid_s;
      en_r      <= en_s;
      cnt_r     <= cnt_s;
    end
  end

  assign s_axil_awready = !aw_held_r;
  assign s_axil_wready  = !w_held_r;
  assign s_axil_bvalid  = bvalid_r;
  assign s_axil_bresp   = RESP_OKAY;
  assign reg_wr_addr    = addr_r;
  assign reg_wr_data    = data_r;
  assign reg_wr_strb    = strb_r;
  assign reg_wr_en      = en_r;

endmodule

// File: tb/tb_axil_reg_if_wr.sv
// tb_axil_reg_if_wr
// Directed self-checking bench for axil_reg_if_wr (TIMEOUT=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axil_reg_if_wr;

  logic        clk;
  logic        rst;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_en;
  logic        wr_wait;
  logic        wr_ack;

  int checks;
  int errors;

  axil_reg_if_wr #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .STRB_WIDTH(4),
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axil_awaddr(awaddr),
    .s_axil_awprot(awprot),
    .s_axil_awvalid(awvalid),
    .s_axil_awready(awready),
    .s_axil_wdata(wdata),
    .s_axil_wstrb(wstrb),
    .s_axil_wvalid(wvalid),
    .s_axil_wready(wready),
    .s_axil_bresp(bresp),
    .s_axil_bvalid(bvalid),
    .s_axil_bready(bready),
    .reg_wr_addr(wr_addr),
    .reg_wr_data(wr_data),
    .reg_wr_strb(wr_strb),
    .reg_wr_en(wr_en),
    .reg_wr_wait(wr_wait),
    .reg_wr_ack(wr_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; awaddr = 32'h0; awprot = 3'b000; awvalid = 1'b0;
    wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b1;
    wr_wait = 1'b0; wr_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({awready, wready, bvalid, bresp, wr_en} !== 6'b110000) begin
      $display("FAIL reset_ctrl: got aw/w/bv/bresp/en=%b want 110000",
               {awready, wready, bvalid, bresp, wr_en});
      errors++;
    end
    checks++;
    if ({wr_addr, wr_data, wr_strb} !== 68'h0) begin
      $display("FAIL reset_data: got addr=%h data=%h strb=%h want zeros", wr_addr, wr_data, wr_strb);
      errors++;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    wr_ack = 1'b1; bready = 1'b1;
    awaddr = 32'h10; awprot = 3'b101; awvalid = 1'b1;
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if ({awready, wready, wr_en, bvalid} !== 4'b0010) begin
      $display("FAIL single_en: got aw/w/en/bv=%b want 0010", {awready, wready, wr_en, bvalid});
      errors++;
    end
    checks++;
    if (wr_addr !== 32'h10 || wr_data !== 32'hDEADBEEF || wr_strb !== 4'hF) begin
      $display("FAIL single_data: got addr=%h data=%h strb=%h want 10 deadbeef f", wr_addr, wr_data, wr_strb);
      errors++;
    end
    @(negedge clk);
    checks++;
    if ({awready, wready, wr_en, bvalid, bresp} !== 6'b110100) begin
      $display("FAIL single_b: got aw/w/en/bv/bresp=%b want 110100", {awready, wready, wr_en, bvalid, bresp});
      errors++;
    end
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b0) begin
      $display("FAIL single_bdone: got bvalid=%b want 0", bvalid);
      errors++;
    end
    wr_ack = 1'b0;
  endtask

  task automatic test_w_first();
    wr_ack = 1'b1;
    wdata = 32'h12345678; wstrb = 4'h5; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({awready, wready, wr_en} !== 3'b100) begin
        $display("FAIL wfirst_wait%0d: got aw/w/en=%b want 100", i, {awready, wready, wr_en});
        errors++;
      end
      if (i < 2) @(negedge clk);
    end
    awaddr = 32'h24; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 32'h24 || wr_data !== 32'h12345678 || wr_strb !== 4'h5) begin
      $display("FAIL wfirst_en: got en=%b addr=%h data=%h strb=%h want 1 24 12345678 5",
               wr_en, wr_addr, wr_data, wr_strb);
      errors++;
    end
    @(negedge clk);
    checks++;
    if ({wr_en, bvalid} !== 2'b01) begin
      $display("FAIL wfirst_b: got en/bv=%b want 01", {wr_en, bvalid});
      errors++;
    end
    @(negedge clk);
    wr_ack = 1'b0;
  endtask

  task automatic test_aw_only();
    awaddr = 32'h40; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({awready, wready, wr_en, bvalid} !== 4'b0100) begin
      $display("FAIL awonly_idle: got aw/w/en/bv=%b want 0100", {awready, wready, wr_en, bvalid});
      errors++;
    end
    wr_ack = 1'b1;
    wdata = 32'hCAFEF00D; wstrb = 4'h3; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 32'h40 || wr_data !== 32'hCAFEF00D) begin
      $display("FAIL awonly_en: got en=%b addr=%h data=%h want 1 40 cafef00d", wr_en, wr_addr, wr_data);
      errors++;
    end
    repeat (2) @(negedge clk);
    wr_ack = 1'b0;
  endtask

  task automatic test_timeout();
    wr_ack = 1'b0; wr_wait = 1'b0;
    awaddr = 32'h50; awvalid = 1'b1; wdata = 32'h1; wstrb = 4'h1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({wr_en, bvalid} !== 2'b10) begin
        $display("FAIL timeout_hold%0d: got en/bv=%b want 10", i, {wr_en, bvalid});
        errors++;
      end
      @(negedge clk);
    end
    checks++;
    if ({wr_en, bvalid, bresp} !== 4'b0100) begin
      $display("FAIL timeout_b: got en/bv/bresp=%b want 0100", {wr_en, bvalid, bresp});
      errors++;
    end
    @(negedge clk);
  endtask

  task automatic test_wait();
    wr_ack = 1'b0; wr_wait = 1'b1;
    awaddr = 32'h60; awvalid = 1'b1; wdata = 32'h2; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({wr_en, bvalid} !== 2'b10) begin
        $display("FAIL wait_hold%0d: got en/bv=%b want 10", i, {wr_en, bvalid});
        errors++;
      end
      @(negedge clk);
    end
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0; wr_wait = 1'b0;
    checks++;
    if ({wr_en, bvalid} !== 2'b01) begin
      $display("FAIL wait_b: got en/bv=%b want 01", {wr_en, bvalid});
      errors++;
    end
    @(negedge clk);
    checks++;
    if ({wr_en, bvalid} !== 2'b00) begin
      $display("FAIL wait_single_b: got en/bv=%b want 00", {wr_en, bvalid});
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    wr_ack = 1'b1; bready = 1'b0;
    awaddr = 32'h30; awvalid = 1'b1; wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({wr_en, bvalid, awready, wready} !== 4'b0111) begin
      $display("FAIL b2b_first_b: got en/bv/aw/w=%b want 0111", {wr_en, bvalid, awready, wready});
      errors++;
    end
    awaddr = 32'h34; awvalid = 1'b1; wdata = 32'h0BADF00D; wstrb = 4'h0; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({wr_en, bvalid, awready, wready} !== 4'b0100 || wr_addr !== 32'h34) begin
        $display("FAIL b2b_pending%0d: got en/bv/aw/w=%b addr=%h want 0100 34",
                 i, {wr_en, bvalid, awready, wready}, wr_addr);
        errors++;
      end
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || bvalid !== 1'b0 || wr_data !== 32'h0BADF00D || wr_strb !== 4'h0) begin
      $display("FAIL b2b_second_en: got en=%b bv=%b data=%h strb=%h want 1 0 0badf00d 0",
               wr_en, bvalid, wr_data, wr_strb);
      errors++;
    end
    @(negedge clk);
    checks++;
    if ({wr_en, bvalid} !== 2'b01) begin
      $display("FAIL b2b_second_b: got en/bv=%b want 01", {wr_en, bvalid});
      errors++;
    end
    @(negedge clk);
    wr_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    wr_ack = 1'b0; wr_wait = 1'b1;
    awaddr = 32'h70; awvalid = 1'b1; wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (wr_en !== 1'b1) begin
      $display("FAIL rstmid_pre: got en=%b want 1", wr_en);
      errors++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({wr_en, bvalid, awready, wready} !== 4'b0011) begin
      $display("FAIL rstmid_async: got en/bv/aw/w=%b want 0011", {wr_en, bvalid, awready, wready});
      errors++;
    end
    @(negedge clk);
    rst = 1'b0; wr_wait = 1'b0; wr_ack = 1'b1;
    awaddr = 32'h80; awvalid = 1'b1; wdata = 32'h88; wstrb = 4'hC; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 32'h80 || wr_data !== 32'h88 || bvalid !== 1'b0) begin
      $display("FAIL rstmid_next_en: got en=%b addr=%h data=%h bv=%b want 1 80 88 0",
               wr_en, wr_addr, wr_data, bvalid);
      errors++;
    end
    @(negedge clk);
    checks++;
    if ({wr_en, bvalid} !== 2'b01) begin
      $display("FAIL rstmid_next_b: got en/bv=%b want 01", {wr_en, bvalid});
      errors++;
    end
    @(negedge clk);
    wr_ack = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_w_first();
    test_aw_only();
    test_timeout();
    test_wait();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
